// File: rtl/syn_pkg.sv
// Shared definitions for the sync line: FSM states, frame geometry and default
// timing constants used by both the master and slave sides.
package syn_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_INFO = 3'd1,
        S_START     = 3'd2,
        S_DATA      = 3'd3,
        S_STOP      = 3'd4
    } syn_state_e;

    localparam int unsigned INFO_BITS = 40;
    localparam int unsigned UTC_W     = 32;
    localparam int unsigned CKS_W     = 8;

    localparam int unsigned BIT_US_DEF      = 4;
    localparam int unsigned SYNC_MIN_US_DEF = 8;
    localparam int unsigned SYNC_MAX_US_DEF = 12;
    localparam int unsigned INFO_WIN_US_DEF = 100;

    localparam int unsigned LOW_W_W = 8;

    // Mod-256 sum of the four UTC bytes.
    function automatic logic [CKS_W-1:0] frame_cks(input logic [UTC_W-1:0] d);
        return d[7:0] + d[15:8] + d[23:16] + d[31:24];
    endfunction

endpackage

// File: rtl/syn_s_lowmeter.sv
// Synchronizes the raw sync pin, detects its edges and measures how many
// microsecond ticks the line stayed low before each rising edge.
module syn_s_lowmeter
    import syn_pkg::*;
#(
    parameter int unsigned SYNC_MAX_US = SYNC_MAX_US_DEF
) (
    input  logic               clk_sys,
    input  logic               rst_n,
    input  logic               pluse_us,
    input  logic               rx_syn,
    output logic               rise,
    output logic               fall,
    output logic               line,
    output logic [LOW_W_W-1:0] low_w
);

    localparam logic [LOW_W_W-1:0] LOW_SAT = LOW_W_W'(SYNC_MAX_US + 1);

    function automatic logic [LOW_W_W-1:0] sat_inc(input logic [LOW_W_W-1:0] v);
        return (v >= LOW_SAT) ? LOW_SAT : v + LOW_W_W'(1);
    endfunction

    logic sync_p0, sync_p1, line_p2;
    logic rise_c, fall_c;

    assign rise_c = sync_p1 & ~line_p2;
    assign fall_c = ~sync_p1 & line_p2;
    assign line   = line_p2;

    // p0/p1: metastability chain; p2: edge-detect stage aligned with rise/fall/low_w
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            line_p2 <= 1'b1;
            rise    <= 1'b0;
            fall    <= 1'b0;
            low_w   <= '0;
        end else begin
            sync_p0 <= rx_syn;
            sync_p1 <= sync_p0;
            line_p2 <= sync_p1;
            rise    <= rise_c;
            fall    <= fall_c;
            // An edge in the same cycle as a tick wins; the tick is dropped.
            if (fall_c)
                low_w <= '0;
            else if (!rise_c && !sync_p1 && pluse_us)
                low_w <= sat_inc(low_w);
        end
    end

endmodule

// File: rtl/syn_s_rx.sv
// Slave receiver for the single-wire sync line: recovers the 1 PPS sync as a
// one-cycle strobe and decodes the following UTC info frame.
module syn_s_rx
    import syn_pkg::*;
#(
    parameter int unsigned SYNC_MIN_US = SYNC_MIN_US_DEF,
    parameter int unsigned SYNC_MAX_US = SYNC_MAX_US_DEF,
    parameter int unsigned BIT_US      = BIT_US_DEF,
    parameter int unsigned INFO_WIN_US = INFO_WIN_US_DEF
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        pluse_us,
    input  logic        rx_syn,
    output logic        fire_sync,
    output logic [31:0] utc_sec,
    output logic        utc_vld,
    output logic        err,
    output logic [7:0]  err_cnt
);

    localparam logic [LOW_W_W-1:0] MIN_W   = LOW_W_W'(SYNC_MIN_US);
    localparam logic [LOW_W_W-1:0] MAX_W   = LOW_W_W'(SYNC_MAX_US);
    localparam logic [7:0]         HALF_M1 = 8'(BIT_US / 2 - 1);
    localparam logic [7:0]         BIT_M1  = 8'(BIT_US - 1);
    localparam logic [15:0]        WIN_M1  = 16'(INFO_WIN_US - 1);
    localparam logic [5:0]         LAST_B  = 6'(INFO_BITS - 1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic               rise, fall, line;
    logic [LOW_W_W-1:0] low_w;

    syn_state_e           state;
    logic [7:0]           tcnt;
    logic [5:0]           bcnt;
    logic [15:0]          wcnt;
    logic [INFO_BITS-1:0] sr;
    logic                 half_tick, bit_tick, shift_en, cks_ok, err_hit;

    syn_s_lowmeter #(
        .SYNC_MAX_US(SYNC_MAX_US)
    ) u_meter (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .pluse_us(pluse_us),
        .rx_syn  (rx_syn),
        .rise    (rise),
        .fall    (fall),
        .line    (line),
        .low_w   (low_w)
    );

    assign half_tick = pluse_us && (tcnt == HALF_M1);
    assign bit_tick  = pluse_us && (tcnt == BIT_M1);
    assign shift_en  = (state == S_DATA) && bit_tick;
    assign cks_ok    = frame_cks(sr[UTC_W-1:0]) == sr[INFO_BITS-1:UTC_W];

    always_comb begin
        err_hit = 1'b0;
        unique case (state)
            S_IDLE:      err_hit = rise && (low_w > MAX_W);
            S_WAIT_INFO: err_hit = !fall && pluse_us && (wcnt == WIN_M1);
            S_STOP:      err_hit = bit_tick && !(line && cks_ok);
            default:     err_hit = 1'b0;
        endcase
    end

    // Frame payload shifts in LSB first; checksum ends up in the top byte.
    always_ff @(posedge clk_sys) begin
        if (shift_en)
            sr <= {line, sr[INFO_BITS-1:1]};
    end

    // Output stage: all strobes registered one cycle after their triggering event
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            tcnt      <= '0;
            bcnt      <= '0;
            wcnt      <= '0;
            fire_sync <= 1'b0;
            utc_vld   <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
            utc_sec   <= '0;
        end else begin
            fire_sync <= 1'b0;
            utc_vld   <= 1'b0;
            err       <= err_hit;
            if (err_hit)
                err_cnt <= sat_inc8(err_cnt);

            unique case (state)
                S_IDLE: begin
                    if (rise && (low_w >= MIN_W) && (low_w <= MAX_W)) begin
                        fire_sync <= 1'b1;
                        wcnt      <= '0;
                        state     <= S_WAIT_INFO;
                    end
                end
                S_WAIT_INFO: begin
                    if (fall) begin
                        tcnt  <= '0;
                        state <= S_START;
                    end else if (pluse_us) begin
                        if (wcnt == WIN_M1)
                            state <= S_IDLE;
                        else
                            wcnt <= wcnt + 16'd1;
                    end
                end
                S_START: begin
                    // A start bit that is high again at mid-bit was a glitch; the window keeps running.
                    if (half_tick) begin
                        tcnt <= '0;
                        if (!line) begin
                            bcnt  <= '0;
                            state <= S_DATA;
                        end else begin
                            state <= S_WAIT_INFO;
                        end
                    end else if (pluse_us) begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                S_DATA: begin
                    if (bit_tick) begin
                        tcnt <= '0;
                        if (bcnt == LAST_B)
                            state <= S_STOP;
                        else
                            bcnt <= bcnt + 6'd1;
                    end else if (pluse_us) begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                S_STOP: begin
                    if (bit_tick) begin
                        state <= S_IDLE;
                        if (line && cks_ok) begin
                            utc_sec <= sr[UTC_W-1:0];
                            utc_vld <= 1'b1;
                        end
                    end else if (pluse_us) begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_syn_s_rx.sv
// Bench for syn_s_rx: line-level stimulus in microsecond units, an ordered
// queue of expected output events and a per-cycle compare process.
module tb_syn_s_rx;

    localparam int US    = 4;   // clk_sys cycles per microsecond tick
    localparam int BIT   = 4;   // info bit period in ticks
    localparam int EV_FIRE = 0;
    localparam int EV_VLD  = 1;
    localparam int EV_ERR  = 2;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } ev_t;

    logic        clk_sys = 1'b0;
    logic        rst_n   = 1'b0;
    logic        pluse_us = 1'b0;
    logic        rx_syn  = 1'b1;
    logic        fire_sync, utc_vld, err;
    logic [31:0] utc_sec;
    logic [7:0]  err_cnt;

    ev_t         expq[$];
    int          checks = 0;
    int          passes = 0;
    logic [31:0] m_utc = '0;
    int          m_cnt = 0;
    int          raw_err = 0;

    syn_s_rx dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .pluse_us (pluse_us),
        .rx_syn   (rx_syn),
        .fire_sync(fire_sync),
        .utc_sec  (utc_sec),
        .utc_vld  (utc_vld),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        int c;
        c = 0;
        forever begin
            @(negedge clk_sys);
            c++;
            pluse_us = (c % US == 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] cks_of(input logic [31:0] d);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) s += int'(d[8*i +: 8]);
        return 8'(s % 256);
    endfunction

    task automatic push_ev(input int kind, input logic [31:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        expq.push_back(e);
        if (kind == EV_ERR) raw_err++;
    endtask

    task automatic pop_expect(input int kind, input string name, output logic [31:0] val);
        ev_t e;
        val = '0;
        checks++;
        if (expq.size() == 0) begin
            $display("FAIL %s: unexpected pulse, got kind %0d, expected none", name, kind);
        end else begin
            e = expq.pop_front();
            val = e.val;
            if (e.kind == kind) passes++;
            else $display("FAIL %s: got event kind %0d, expected kind %0d", name, kind, e.kind);
        end
    endtask

    // Event order and held outputs are checked every cycle.
    initial begin
        logic [31:0] v;
        forever begin
            @(posedge clk_sys);
            #1;
            if (fire_sync) pop_expect(EV_FIRE, "fire_sync", v);
            if (utc_vld) begin
                pop_expect(EV_VLD, "utc_vld", v);
                m_utc = v;
            end
            if (err) begin
                pop_expect(EV_ERR, "err", v);
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            end
            chk("utc_sec", utc_sec, m_utc);
            chk("err_cnt", err_cnt, 32'(m_cnt));
        end
    end

    task automatic drive(input logic lvl, input int n_us);
        rx_syn = lvl;
        repeat (n_us * US) @(negedge clk_sys);
    endtask

    task automatic wait_drain(input string name, input int bound);
        int n;
        n = 0;
        while (expq.size() != 0 && n < bound) begin
            @(negedge clk_sys);
            n++;
        end
        chk(name, 32'(expq.size()), 0);
        expq.delete();
    endtask

    task automatic do_reset();
        rx_syn = 1'b1;
        rst_n  = 1'b0;
        m_utc  = '0;
        m_cnt  = 0;
        raw_err = 0;
        chk("pending at reset", 32'(expq.size()), 0);
        expq.delete();
        repeat (3) @(negedge clk_sys);
        chk("rst fire_sync", 32'(fire_sync), 0);
        chk("rst utc_vld", 32'(utc_vld), 0);
        chk("rst err", 32'(err), 0);
        chk("rst err_cnt", 32'(err_cnt), 0);
        chk("rst utc_sec", utc_sec, 0);
        rst_n = 1'b1;
    endtask

    // Start bit, 32 UTC bits and 8 checksum bits LSB first, then the stop bit.
    task automatic send_frame(input logic [31:0] d, input logic [7:0] c, input logic stop,
                              input int abort_at);
        logic [39:0] payload;
        payload = {c, d};
        drive(1'b0, BIT);
        for (int i = 0; i < 40; i++) begin
            if (i == abort_at) begin
                do_reset();
                return;
            end
            drive(payload[i], BIT);
        end
        drive(stop, BIT);
    endtask

    task automatic good_sync();
        push_ev(EV_FIRE, 0);
        drive(1'b0, $urandom_range(9, 11));
    endtask

    task automatic random_item();
        logic [31:0] d;
        logic [7:0]  c;
        int          kind;
        kind = $urandom_range(0, 5);
        d = $urandom;
        case (kind)
            0: begin
                drive(1'b0, $urandom_range(2, 5));
                drive(1'b1, $urandom_range(5, 10));
            end
            1: begin
                push_ev(EV_ERR, 0);
                drive(1'b0, $urandom_range(15, 20));
                drive(1'b1, 5);
            end
            2: begin
                good_sync();
                drive(1'b1, $urandom_range(5, 60));
                push_ev(EV_VLD, d);
                send_frame(d, cks_of(d), 1'b1, -1);
                drive(1'b1, $urandom_range(3, 10));
            end
            3: begin
                good_sync();
                drive(1'b1, $urandom_range(5, 60));
                push_ev(EV_ERR, 0);
                c = cks_of(d) ^ 8'($urandom_range(1, 255));
                send_frame(d, c, 1'b1, -1);
                drive(1'b1, $urandom_range(3, 10));
            end
            4: begin
                // Keep the checksum MSB high so the low stop bit alone is a short glitch afterwards.
                c = cks_of(d);
                while (c[7] == 1'b0) begin
                    d = $urandom;
                    c = cks_of(d);
                end
                good_sync();
                drive(1'b1, $urandom_range(5, 60));
                push_ev(EV_ERR, 0);
                send_frame(d, c, 1'b0, -1);
                drive(1'b1, $urandom_range(3, 10));
            end
            default: begin
                good_sync();
                push_ev(EV_ERR, 0);
                drive(1'b1, 110);
            end
        endcase
    endtask

    initial begin
        int          lat, k, n;
        logic [31:0] d2, d3, d4;
        logic [7:0]  c;

        repeat (5) @(negedge clk_sys);
        chk("reset fire_sync", 32'(fire_sync), 0);
        chk("reset utc_vld", 32'(utc_vld), 0);
        chk("reset err", 32'(err), 0);
        chk("reset err_cnt", 32'(err_cnt), 0);
        chk("reset utc_sec", utc_sec, 0);
        rst_n = 1'b1;
        drive(1'b1, 5);

        chk("model checksum", 32'(cks_of(32'h12345678)), 32'h14);

        // Nominal sync, latency, then a good frame 20 us later
        push_ev(EV_FIRE, 0);
        drive(1'b0, 10);
        rx_syn = 1'b1;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk_sys);
            #1;
            if (fire_sync && lat == 0) lat = i;
        end
        chk("fire latency", 32'(lat), 4);
        @(negedge clk_sys);
        drive(1'b1, 18);
        push_ev(EV_VLD, 32'h12345678);
        send_frame(32'h12345678, 8'h14, 1'b1, -1);
        drive(1'b1, 5);
        wait_drain("drain good frame", 200);
        chk("good utc_sec", utc_sec, 32'h12345678);
        chk("good err_cnt", 32'(err_cnt), 0);

        // Bad checksum
        push_ev(EV_FIRE, 0);
        drive(1'b0, 10);
        drive(1'b1, 20);
        push_ev(EV_ERR, 0);
        send_frame(32'h12345678, 8'h15, 1'b1, -1);
        drive(1'b1, 5);
        wait_drain("drain bad cks", 200);
        chk("bad cks utc_sec", utc_sec, 32'h12345678);
        chk("bad cks err_cnt", 32'(err_cnt), 1);

        // Short glitch, then an over-long pulse
        drive(1'b0, 5);
        drive(1'b1, 5);
        wait_drain("drain glitch", 50);
        chk("glitch err_cnt", 32'(err_cnt), 1);
        push_ev(EV_ERR, 0);
        drive(1'b0, 20);
        drive(1'b1, 5);
        wait_drain("drain long", 50);
        chk("long err_cnt", 32'(err_cnt), 2);

        // Sync with no frame: error after the info window
        push_ev(EV_FIRE, 0);
        push_ev(EV_ERR, 0);
        drive(1'b0, 10);
        rx_syn = 1'b1;
        k = 0;
        while (!fire_sync && k < 20) begin
            @(posedge clk_sys);
            #1;
            k++;
        end
        n = 0;
        while (!err && n < 600) begin
            @(posedge clk_sys);
            #1;
            n++;
        end
        chk("timeout ticks", 32'((n + 3) / US), 100);
        @(negedge clk_sys);
        drive(1'b1, 5);
        wait_drain("drain timeout", 50);
        chk("timeout err_cnt", 32'(err_cnt), 3);
        d2 = $urandom;
        push_ev(EV_FIRE, 0);
        drive(1'b0, 10);
        drive(1'b1, 30);
        push_ev(EV_VLD, d2);
        send_frame(d2, cks_of(d2), 1'b1, -1);
        drive(1'b1, 5);
        wait_drain("drain after timeout", 200);
        chk("after timeout utc_sec", utc_sec, d2);

        // Stop bit low
        d3 = 32'h0000_0080;
        c = cks_of(d3);
        push_ev(EV_FIRE, 0);
        drive(1'b0, 10);
        drive(1'b1, 20);
        push_ev(EV_ERR, 0);
        send_frame(d3, c, 1'b0, -1);
        drive(1'b1, 5);
        wait_drain("drain stop low", 200);
        chk("stop low err_cnt", 32'(err_cnt), 4);
        chk("stop low utc_sec", utc_sec, d2);

        for (int i = 0; i < 20; i++) random_item();
        wait_drain("drain random", 400);

        // Saturate the error counter
        while (raw_err < 260) begin
            push_ev(EV_ERR, 0);
            drive(1'b0, $urandom_range(15, 20));
            drive(1'b1, 5);
        end
        wait_drain("drain saturate", 100);
        chk("saturated err_cnt", 32'(err_cnt), 255);

        // Reset during data bit 20, then a clean decode
        d3 = $urandom;
        push_ev(EV_FIRE, 0);
        drive(1'b0, 10);
        drive(1'b1, 20);
        send_frame(d3, cks_of(d3), 1'b1, 20);
        drive(1'b1, 10);
        chk("post reset err_cnt", 32'(err_cnt), 0);
        chk("post reset utc_sec", utc_sec, 0);
        d4 = $urandom;
        push_ev(EV_FIRE, 0);
        drive(1'b0, 10);
        drive(1'b1, 25);
        push_ev(EV_VLD, d4);
        send_frame(d4, cks_of(d4), 1'b1, -1);
        drive(1'b1, 5);
        wait_drain("drain final", 200);
        chk("final utc_sec", utc_sec, d4);
        chk("final err_cnt", 32'(err_cnt), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
